// File: rtl/uno_pkg.sv
// Shared types and constants for the UNO hand storage and card-rule logic.
package uno_pkg;

  localparam int MAX_CARDS = 108;
  localparam int IDX_W     = 7;

  typedef struct packed {
    logic [1:0] color;
    logic [3:0] value;
  } card_t;

  localparam card_t EMPTY_CARD = '{color: 2'b11, value: 4'hF};

  localparam logic [3:0] V_SKIP  = 4'd10;
  localparam logic [3:0] V_REV   = 4'd11;
  localparam logic [3:0] V_DRAW2 = 4'd12;
  localparam logic [3:0] V_WILD  = 4'd13;
  localparam logic [3:0] V_WILD4 = 4'd14;

  // Cursor value that points at the draw deck rather than a hand slot.
  localparam logic [IDX_W-1:0] DECK_IDX = IDX_W'(MAX_CARDS);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO  = IDX_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAW  = 2'd2,
    ST_COLOR = 2'd3
  } state_t;

endpackage

// File: rtl/uno_legal_check.sv
// Combinational UNO play rule: a card may go on the pile if it is wild or
// matches the top card's colour or value.
module uno_legal_check
  import uno_pkg::*;
(
  input  logic [5:0] i_card,
  input  logic [5:0] i_prev,
  output logic       o_legal,
  output logic       o_is_wild
);

  card_t card;
  card_t prev;

  always_comb begin
    card      = card_t'(i_card);
    prev      = card_t'(i_prev);
    o_is_wild = (card.value >= V_WILD);
    o_legal   = o_is_wild || (card.color == prev.color) || (card.value == prev.value);
  end

endmodule

// File: rtl/uno_hand_store.sv
// Player hand array, cursor and discard-pile controller. Valid/ready contract:
// i_deal_valid / i_draw_valid are single-cycle strobes with no back-pressure;
// o_draw_req stays high until the cycle after i_draw_valid is seen in DRAW.
module uno_hand_store
  import uno_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_left,
  input  logic                   i_right,
  input  logic                   i_select,
  input  logic                   i_deal_valid,
  input  logic [5:0]             i_deal_card,
  output logic                   o_draw_req,
  input  logic                   i_draw_valid,
  input  logic [5:0]             i_draw_card,
  output logic [MAX_CARDS*6-1:0] o_hands,
  output logic [IDX_W-1:0]       o_hand_num,
  output logic [IDX_W-1:0]       o_index,
  output logic [5:0]             o_prev_card,
  output logic                   o_select_color,
  output logic                   o_busy,
  output logic                   o_turn_done,
  output logic [1:0]             o_state
);

  state_t           state_q, state_d;
  card_t            hands_q [MAX_CARDS];
  card_t            hands_d [MAX_CARDS];
  logic [IDX_W-1:0] hand_num_q, hand_num_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] shift_j_q, shift_j_d;
  card_t            prev_q, prev_d;
  logic             turn_done_q, turn_done_d;

  card_t sel_card;
  logic  sel_legal;
  logic  sel_wild;

  assign sel_card = (index_q < DECK_IDX) ? hands_q[index_q] : EMPTY_CARD;

  uno_legal_check u_legal (
    .i_card    (sel_card),
    .i_prev    (prev_q),
    .o_legal   (sel_legal),
    .o_is_wild (sel_wild)
  );

  always_comb begin
    state_d     = state_q;
    hands_d     = hands_q;
    hand_num_d  = hand_num_q;
    index_d     = index_q;
    shift_j_d   = shift_j_q;
    prev_d      = prev_q;
    turn_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_deal_valid) begin
          if (hand_num_q != DECK_IDX) begin
            hands_d[hand_num_q] = card_t'(i_deal_card);
            hand_num_d          = hand_num_q + IDX_ONE;
          end
        end else if (i_select) begin
          if (index_q == DECK_IDX) begin
            if (hand_num_q != DECK_IDX) state_d = ST_DRAW;
          end else if (sel_legal) begin
            prev_d    = sel_card;
            shift_j_d = index_q;
            state_d   = ST_SHIFT;
          end
        end else if (i_right) begin
          if (index_q == DECK_IDX) begin
            if (hand_num_q != '0) index_d = '0;
          end else if (index_q == hand_num_q - IDX_ONE) begin
            index_d = DECK_IDX;
          end else begin
            index_d = index_q + IDX_ONE;
          end
        end else if (i_left) begin
          if (index_q == DECK_IDX) begin
            if (hand_num_q != '0) index_d = hand_num_q - IDX_ONE;
          end else if (index_q == '0) begin
            index_d = DECK_IDX;
          end else begin
            index_d = index_q - IDX_ONE;
          end
        end
      end

      // One slot moves down per cycle; the last cycle blanks the old tail slot.
      ST_SHIFT: begin
        if (shift_j_q + IDX_ONE < hand_num_q) begin
          hands_d[shift_j_q] = hands_q[shift_j_q + IDX_ONE];
          shift_j_d          = shift_j_q + IDX_ONE;
        end else begin
          hands_d[hand_num_q - IDX_ONE] = EMPTY_CARD;
          hand_num_d                    = hand_num_q - IDX_ONE;
          if (hand_num_q == IDX_ONE) begin
            index_d = DECK_IDX;
          end else if (index_q > hand_num_q - IDX_TWO) begin
            index_d = hand_num_q - IDX_TWO;
          end
          if (prev_q.value >= V_WILD) begin
            state_d = ST_COLOR;
          end else begin
            turn_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_DRAW: begin
        if (i_draw_valid) begin
          hands_d[hand_num_q] = card_t'(i_draw_card);
          hand_num_d          = hand_num_q + IDX_ONE;
          turn_done_d         = 1'b1;
          state_d             = ST_IDLE;
        end
      end

      ST_COLOR: begin
        if (i_select) begin
          turn_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (i_right) begin
          prev_d.color = prev_q.color + 2'd1;
        end else if (i_left) begin
          prev_d.color = prev_q.color - 2'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      for (int k = 0; k < MAX_CARDS; k++) hands_q[k] <= EMPTY_CARD;
      hand_num_q  <= '0;
      index_q     <= DECK_IDX;
      shift_j_q   <= '0;
      prev_q      <= '0;
      turn_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hands_q     <= hands_d;
      hand_num_q  <= hand_num_d;
      index_q     <= index_d;
      shift_j_q   <= shift_j_d;
      prev_q      <= prev_d;
      turn_done_q <= turn_done_d;
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_CARDS; k++) o_hands[k*6 +: 6] = hands_q[k];
  end

  assign o_hand_num     = hand_num_q;
  assign o_index        = index_q;
  assign o_prev_card    = prev_q;
  assign o_draw_req     = (state_q == ST_DRAW);
  assign o_select_color = (state_q == ST_COLOR);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_turn_done    = turn_done_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_uno_hand_store.sv
// Bench for uno_hand_store: queue-based hand model, directed scenarios and
// randomized key/deal/draw traffic; turn completions checked by a monitor.
module tb_uno_hand_store;
  import uno_pkg::*;

  localparam int MAXC = MAX_CARDS;
  localparam int DECK = MAX_CARDS;

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic                i_left = 1'b0, i_right = 1'b0, i_select = 1'b0;
  logic                i_deal_valid = 1'b0;
  logic [5:0]          i_deal_card = '0;
  logic                i_draw_valid = 1'b0;
  logic [5:0]          i_draw_card = '0;
  logic                o_draw_req;
  logic [MAXC*6-1:0]   o_hands;
  logic [IDX_W-1:0]    o_hand_num, o_index;
  logic [5:0]          o_prev_card;
  logic                o_select_color, o_busy, o_turn_done;
  logic [1:0]          o_state;

  always #5 i_clk = ~i_clk;

  uno_hand_store dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_left(i_left), .i_right(i_right), .i_select(i_select),
    .i_deal_valid(i_deal_valid), .i_deal_card(i_deal_card),
    .o_draw_req(o_draw_req),
    .i_draw_valid(i_draw_valid), .i_draw_card(i_draw_card),
    .o_hands(o_hands), .o_hand_num(o_hand_num), .o_index(o_index),
    .o_prev_card(o_prev_card), .o_select_color(o_select_color),
    .o_busy(o_busy), .o_turn_done(o_turn_done), .o_state(o_state)
  );

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  // Reference model
  logic [5:0] m_hand[$];
  int         m_idx;
  logic [5:0] m_prev;
  bit         m_color;
  bit         m_draw_pending;
  int         g_dly = -1;
  logic [5:0] g_card = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_hands(input string name);
    logic [MAXC*6-1:0] e;
    for (int k = 0; k < MAXC; k++) e[k*6 +: 6] = (k < m_hand.size()) ? m_hand[k] : 6'h3F;
    checks++;
    if (o_hands !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, o_hands, e);
    end
  endtask

  task automatic check_state(input string name);
    chk({name, "_num"}, o_hand_num, m_hand.size());
    chk({name, "_idx"}, o_index, m_idx);
    chk({name, "_prev"}, o_prev_card, m_prev);
    chk({name, "_selcolor"}, o_select_color, m_color);
    chk({name, "_busy"}, o_busy, m_color);
    chk({name, "_drawreq"}, o_draw_req, 0);
    chk_hands({name, "_hands"});
  endtask

  task automatic model_reset();
    m_hand.delete();
    m_idx = DECK;
    m_prev = 6'h00;
    m_color = 0;
    m_draw_pending = 0;
    exp_q.delete();
  endtask

  function automatic bit legal(input logic [5:0] c, input logic [5:0] p);
    return (c[3:0] >= 4'd13) || (c[5:4] == p[5:4]) || (c[3:0] == p[3:0]);
  endfunction

  task automatic push_exp();
    exp_q.push_back({7'(m_hand.size()), 7'(m_idx), m_prev});
  endtask

  task automatic model_event(input bit d, input logic [5:0] dc, input bit s, input bit r, input bit l);
    int n;
    n = m_hand.size();
    if (m_color) begin
      if (s) begin
        m_color = 0;
        push_exp();
      end else if (r) m_prev[5:4] = m_prev[5:4] + 2'd1;
      else if (l) m_prev[5:4] = m_prev[5:4] - 2'd1;
    end else if (d) begin
      if (n < MAXC) m_hand.push_back(dc);
    end else if (s) begin
      if (m_idx == DECK) begin
        if (n < MAXC) m_draw_pending = 1;
      end else if (legal(m_hand[m_idx], m_prev)) begin
        m_prev = m_hand[m_idx];
        m_hand.delete(m_idx);
        n = m_hand.size();
        if (n == 0) m_idx = DECK;
        else if (m_idx > n - 1) m_idx = n - 1;
        if (m_prev[3:0] >= 4'd13) m_color = 1;
        else push_exp();
      end
    end else if (r) begin
      if (m_idx == DECK) begin
        if (n != 0) m_idx = 0;
      end else if (m_idx == n - 1) m_idx = DECK;
      else m_idx++;
    end else if (l) begin
      if (m_idx == DECK) begin
        if (n != 0) m_idx = n - 1;
      end else if (m_idx == 0) m_idx = DECK;
      else m_idx--;
    end
  endtask

  task automatic clear_inputs();
    i_left = 0; i_right = 0; i_select = 0;
    i_deal_valid = 0; i_draw_valid = 0;
  endtask

  task automatic noise();
    i_left = 1'($urandom_range(0, 1));
    i_right = 1'($urandom_range(0, 1));
    i_deal_valid = 1'($urandom_range(0, 1));
    i_deal_card = 6'($urandom_range(0, 63));
  endtask

  task automatic do_draw();
    int dly;
    logic [5:0] card;
    dly = (g_dly >= 0) ? g_dly : int'($urandom_range(0, 3));
    card = (g_dly >= 0) ? g_card : {2'($urandom_range(0, 3)), 4'($urandom_range(0, 14))};
    chk("draw_req_rise", o_draw_req, 1);
    repeat (dly) begin
      noise();
      @(negedge i_clk);
      chk("draw_req_hold", o_draw_req, 1);
    end
    clear_inputs();
    i_draw_valid = 1;
    i_draw_card = card;
    m_hand.push_back(card);
    m_draw_pending = 0;
    push_exp();
    @(negedge i_clk);
    clear_inputs();
    chk("draw_req_fall", o_draw_req, 0);
  endtask

  task automatic settle(input string name);
    int n;
    n = 0;
    if (m_draw_pending) begin
      do_draw();
    end else begin
      while (o_busy && !o_select_color && !o_draw_req && n < 400) begin
        noise();
        i_draw_valid = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        n++;
      end
      clear_inputs();
      if (n >= 400) chk("settle_timeout", 1, 0);
    end
    check_state(name);
  endtask

  task automatic ev(input string name, input bit d, input logic [5:0] dc, input bit s,
                    input bit r, input bit l, input bit dv);
    @(negedge i_clk);
    i_deal_valid = d; i_deal_card = dc;
    i_select = s; i_right = r; i_left = l;
    i_draw_valid = dv; i_draw_card = 6'($urandom_range(0, 63));
    model_event(d, dc, s, r, l);
    @(negedge i_clk);
    clear_inputs();
    chk({name, "_prev_t1"}, o_prev_card, m_prev);
    settle(name);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 0;
    clear_inputs();
    model_reset();
    #1;
    check_state("reset");
    chk("reset_turn_done", o_turn_done, 0);
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  // Completion monitor: every o_turn_done pulse must match the next expected turn result.
  always @(negedge i_clk) begin
    logic [19:0] e;
    if (i_rst_n && o_turn_done) begin
      if (exp_q.size() == 0) begin
        chk("turn_done_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("turn_done_state", {o_hand_num, o_index, o_prev_card}, e);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge i_clk);
    do_reset();

    ev("deal0", 1, 6'h01, 0, 0, 0, 0);
    ev("deal1", 1, 6'h12, 0, 0, 0, 0);
    ev("deal2", 1, 6'h2D, 0, 0, 0, 0);
    chk("three_deals_num", o_hand_num, 3);
    chk("three_deals_idx", o_index, 108);

    ev("right_deck", 0, 0, 0, 1, 0, 0);
    chk("right_from_deck", o_index, 0);
    ev("left_zero", 0, 0, 0, 0, 1, 0);
    chk("left_from_zero", o_index, 108);
    ev("left_deck", 0, 0, 0, 0, 1, 0);
    chk("left_from_deck", o_index, 2);
    ev("right_last", 0, 0, 0, 1, 0, 0);
    chk("right_from_last", o_index, 108);

    ev("to_slot0", 0, 0, 0, 1, 0, 0);
    ev("play0", 0, 0, 1, 0, 0, 0);
    chk("play0_prev", o_prev_card, 6'h01);
    chk("play0_idx", o_index, 0);

    ev("illegal", 0, 0, 1, 0, 0, 0);
    chk("illegal_num", o_hand_num, 2);

    ev("to_wild", 0, 0, 0, 1, 0, 0);
    ev("play_wild", 0, 0, 1, 0, 0, 0);
    chk("wild_selcolor", o_select_color, 1);
    ev("color_r1", 0, 0, 0, 1, 0, 0);
    ev("color_r2", 0, 0, 0, 1, 0, 0);
    chk("color_prev", o_prev_card, 6'h0D);
    ev("color_sel", 0, 0, 1, 0, 0, 0);

    ev("to_deck", 0, 0, 0, 0, 1, 0);
    g_dly = 3; g_card = 6'h35;
    ev("draw", 0, 0, 1, 0, 0, 0);
    g_dly = -1;
    chk("draw_slot", o_hands[6 +: 6], 6'h35);

    ev("deal_and_right", 1, 6'h07, 0, 1, 0, 0);
    chk("deal_and_right_idx", o_index, 108);
    ev("spurious_draw", 0, 0, 0, 0, 0, 1);

    // Reset in the middle of compaction
    do_reset();
    ev("rs_deal_w", 1, 6'h0E, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) ev("rs_deal", 1, 6'($urandom_range(0, 45)), 0, 0, 0, 0);
    ev("rs_right", 0, 0, 0, 1, 0, 0);
    @(negedge i_clk);
    i_select = 1;
    @(negedge i_clk);
    i_select = 0;
    @(negedge i_clk);
    chk("mid_shift_busy", o_busy, 1);
    i_rst_n = 0;
    model_reset();
    #1;
    check_state("mid_shift_reset");
    @(negedge i_clk);
    i_rst_n = 1;

    // Full hand: extra deal dropped, deck select ignored
    for (int k = 0; k < MAXC; k++) ev("fill", 1, {2'($urandom_range(0, 3)), 4'($urandom_range(0, 14))}, 0, 0, 0, 0);
    ev("fill_extra", 1, 6'h05, 0, 0, 0, 0);
    chk("full_num", o_hand_num, 108);
    ev("full_draw", 0, 0, 1, 0, 0, 0);
    chk("full_no_draw", o_draw_req, 0);
    do_reset();

    for (int t = 0; t < 400; t++) begin
      int op;
      logic [5:0] c;
      op = $urandom_range(0, 99);
      c = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 14))};
      if (op < 30) ev("rnd_deal", 1, c, 0, 0, 0, 0);
      else if (op < 50) ev("rnd_right", 0, 0, 0, 1, 0, 0);
      else if (op < 65) ev("rnd_left", 0, 0, 0, 0, 1, 0);
      else if (op < 90) ev("rnd_select", 0, 0, 1, 0, 0, 0);
      else ev("rnd_combo", 1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge i_clk);
    chk("pending_turn_done", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
